// File: rtl/gf_chisq_pkg.sv
// Shared widths, overflow constant and FSM encoding for the chi-square
// best-fit selection blocks of the GigaFitter pipeline.
package gf_chisq_pkg;

  localparam int CHISQBITS = 32;
  localparam int IDBITS    = 8;
  localparam int CNTBITS   = 6;

  localparam logic [CHISQBITS-1:0] CHISQ_OVF = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    HOLD  = 2'b10
  } state_t;

endpackage

// File: rtl/chisq_best_select_if.sv
// Fit-stream input and best-record output of chisq_best_select, plus the cut.
interface chisq_best_select_if #(
  parameter int CHISQBITS = gf_chisq_pkg::CHISQBITS,
  parameter int IDBITS    = gf_chisq_pkg::IDBITS,
  parameter int CNTBITS   = gf_chisq_pkg::CNTBITS
);

  logic [CHISQBITS-1:0] chisq_in;
  logic [IDBITS-1:0]    fit_id;
  logic                 in_last;
  logic                 in_valid;
  logic                 in_ready;
  logic [CHISQBITS-1:0] chisq_cut;

  logic [CHISQBITS-1:0] best_chisq;
  logic [IDBITS-1:0]    best_id;
  logic [CNTBITS-1:0]   nfits;
  logic                 best_pass;
  logic                 out_valid;
  logic                 out_ready;

  // Master feeds fits and consumes records; slave is the selector.
  modport master (
    output chisq_in, fit_id, in_last, in_valid, chisq_cut, out_ready,
    input  in_ready, best_chisq, best_id, nfits, best_pass, out_valid
  );

  modport slave (
    input  chisq_in, fit_id, in_last, in_valid, chisq_cut, out_ready,
    output in_ready, best_chisq, best_id, nfits, best_pass, out_valid
  );

endinterface

// File: rtl/chisq_min_cmp.sv
// Unsigned min/cut comparator: decides whether the candidate replaces the
// current best and whether the resulting best passes the chi-square cut.
module chisq_min_cmp #(
  parameter int W = gf_chisq_pkg::CHISQBITS
) (
  input  logic [W-1:0] best,
  input  logic [W-1:0] cand,
  input  logic [W-1:0] cut,
  output logic         take_new,
  output logic         pass
);

  localparam logic [W-1:0] OVF = '1;

  logic [W-1:0] updated;

  // Strict compare: on a tie the earlier fit is kept.
  assign take_new = (cand < best);
  assign updated  = take_new ? cand : best;
  assign pass     = (updated <= cut) && (updated != OVF);

endmodule

// File: rtl/chisq_best_select.sv
// Keeps the minimum chi-square of each road and holds one registered
// best-fit record per road until the downstream stage accepts it.
module chisq_best_select #(
  parameter int CHISQBITS = gf_chisq_pkg::CHISQBITS,
  parameter int IDBITS    = gf_chisq_pkg::IDBITS,
  parameter int CNTBITS   = gf_chisq_pkg::CNTBITS
) (
  input logic               clk,
  input logic               rst_n,
  chisq_best_select_if.slave bus
);

  import gf_chisq_pkg::*;

  localparam logic [CHISQBITS-1:0] OVF     = '1;
  localparam logic [CNTBITS-1:0]   CNT_MAX = '1;

  state_t               state;
  logic [CHISQBITS-1:0] best_chisq;
  logic [IDBITS-1:0]    best_id;
  logic [CNTBITS-1:0]   nfits;
  logic                 best_pass;

  logic                 in_xfer;
  logic [CHISQBITS-1:0] cmp_best;
  logic                 take_new;
  logic                 pass;

  assign in_xfer = bus.in_valid && (state != HOLD);

  // In IDLE the first fit must always win, so compare it against overflow;
  // an overflow first fit still yields the right (all-ones) final value.
  assign cmp_best = (state == IDLE) ? OVF : best_chisq;

  chisq_min_cmp #(.W(CHISQBITS)) u_cmp (
    .best     (cmp_best),
    .cand     (bus.chisq_in),
    .cut      (bus.chisq_cut),
    .take_new (take_new),
    .pass     (pass)
  );

  // NOTE: sequential state uses non-blocking assignments only, and every
  // register is given its value on the asynchronous reset branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      best_chisq <= OVF;
      best_id    <= '0;
      nfits      <= '0;
      best_pass  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_xfer) begin
            best_chisq <= bus.chisq_in;
            best_id    <= bus.fit_id;
            nfits      <= CNTBITS'(1);
            if (bus.in_last) begin
              best_pass <= pass;
              state     <= HOLD;
            end else begin
              state     <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_xfer) begin
            if (take_new) begin
              best_chisq <= bus.chisq_in;
              best_id    <= bus.fit_id;
            end
            if (nfits != CNT_MAX) nfits <= nfits + CNTBITS'(1);
            if (bus.in_last) begin
              best_pass <= pass;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake flags decode the state register only, so out_ready never
  // reaches in_ready combinationally.
  assign bus.in_ready   = (state != HOLD);
  assign bus.out_valid  = (state == HOLD);
  assign bus.best_chisq = best_chisq;
  assign bus.best_id    = best_id;
  assign bus.nfits      = nfits;
  assign bus.best_pass  = best_pass;

endmodule

// File: tb/tb_chisq_best_select.sv
// Self-checking bench for chisq_best_select: directed road table, hand-written
// backpressure / saturation / reset sequences, and random roads vs a model.
module tb_chisq_best_select;

  import gf_chisq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  chisq_best_select_if #(.CHISQBITS(32), .IDBITS(8), .CNTBITS(6)) bus ();

  chisq_best_select #(.CHISQBITS(32), .IDBITS(8), .CNTBITS(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one fit starting at a negedge; returns on the negedge after transfer.
  task automatic push(input logic [31:0] c, input logic [7:0] id, input logic last);
    int guard = 0;
    bus.chisq_in = c;
    bus.fit_id   = id;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("push_timeout", 64'd0, 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Wait for a record, compare it, let it transfer, confirm it is not repeated.
  task automatic get_record(input string name, input logic [31:0] eb, input logic [7:0] eid,
                            input logic [5:0] en, input logic ep);
    int guard = 0;
    bus.out_ready = 1'b1;
    while (!bus.out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({name, "_chisq"}, 64'(bus.best_chisq), 64'(eb));
    check({name, "_id"},    64'(bus.best_id), 64'(eid));
    check({name, "_nfits"}, 64'(bus.nfits), 64'(en));
    check({name, "_pass"},  64'(bus.best_pass), 64'(ep));
    @(posedge clk);
    @(negedge clk);
    check({name, "_no_dup"}, 64'(bus.out_valid), 64'd0);
  endtask

  typedef struct {
    int          n;
    logic [31:0] c   [4];
    logic [7:0]  id  [4];
    logic [31:0] cut;
    logic [31:0] e_best;
    logic [7:0]  e_id;
    logic [5:0]  e_n;
    logic        e_pass;
  } road_t;

  road_t roads [5];

  // Reference model: first occurrence of the minimum, saturating count.
  logic [31:0] m_c [$];
  logic [7:0]  m_id[$];

  initial begin
    logic [31:0] mb, cut, v, snap_c;
    logic [7:0]  mi, snap_id;
    logic [5:0]  snap_n;
    int          len;

    roads[0] = '{3, '{32'h40, 32'h10, 32'h30, 0}, '{8'd1, 8'd2, 8'd3, 0}, 32'h20, 32'h10, 8'd2, 6'd3, 1'b1};
    roads[1] = '{2, '{32'h25, 32'h25, 0, 0}, '{8'd7, 8'd9, 0, 0}, 32'h20, 32'h25, 8'd7, 6'd2, 1'b0};
    roads[2] = '{2, '{32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0}, '{8'd4, 8'd5, 0, 0}, 32'hFFFFFFFF,
                 32'hFFFFFFFF, 8'd4, 6'd2, 1'b0};
    roads[3] = '{1, '{32'h20, 0, 0, 0}, '{8'hAB, 0, 0, 0}, 32'h20, 32'h20, 8'hAB, 6'd1, 1'b1};
    roads[4] = '{4, '{32'h7, 32'h3, 32'h3, 32'h9}, '{8'd1, 8'd2, 8'd3, 8'd4}, 32'h2,
                 32'h3, 8'd2, 6'd4, 1'b0};

    bus.chisq_in  = '0;
    bus.fit_id    = '0;
    bus.in_last   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.chisq_cut = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready), 64'd1);
    check("rst_chisq",     64'(bus.best_chisq), 64'(CHISQ_OVF));
    check("rst_id",        64'(bus.best_id), 64'd0);
    check("rst_nfits",     64'(bus.nfits), 64'd0);
    check("rst_pass",      64'(bus.best_pass), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 5; r++) begin
      bus.chisq_cut = roads[r].cut;
      for (int f = 0; f < roads[r].n; f++) begin
        push(roads[r].c[f], roads[r].id[f], f == roads[r].n - 1);
        // out_valid must appear exactly one cycle after the last transfer.
        check($sformatf("road%0d_fit%0d_valid", r, f), 64'(bus.out_valid),
              64'(f == roads[r].n - 1));
      end
      get_record($sformatf("road%0d", r), roads[r].e_best, roads[r].e_id,
                 roads[r].e_n, roads[r].e_pass);
    end

    // Backpressure: record held for 5 cycles while the next road waits.
    bus.out_ready = 1'b0;
    bus.chisq_cut = 32'h100;
    push(32'h55, 8'd11, 1'b1);
    snap_c = bus.best_chisq; snap_id = bus.best_id; snap_n = bus.nfits;
    check("bp_held_chisq", 64'(snap_c), 64'h55);
    bus.chisq_in = 32'h66; bus.fit_id = 8'd12; bus.in_last = 1'b1; bus.in_valid = 1'b1;
    bus.chisq_cut = 32'h0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_in_ready_%0d", k), 64'(bus.in_ready), 64'd0);
      check($sformatf("bp_out_valid_%0d", k), 64'(bus.out_valid), 64'd1);
      check($sformatf("bp_stable_%0d", k),
            {24'd0, bus.best_chisq, bus.best_id}, {24'd0, snap_c, snap_id});
      @(negedge clk);
    end
    check("bp_pass_frozen", 64'(bus.best_pass), 64'd1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_idle", 64'(bus.out_valid), 64'd0);
    check("bp_release_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    get_record("bp_next", 32'h66, 8'd12, 6'd1, 1'b0);
    check("bp_nfits_snap", 64'(snap_n), 64'd1);

    // Saturation: 70 fits, minimum placed beyond the counter limit.
    bus.chisq_cut = 32'd60;
    for (int f = 0; f < 70; f++) begin
      v = (f == 65) ? 32'd50 : 32'($urandom_range(100, 1000));
      push(v, 8'(f), f == 69);
    end
    get_record("sat", 32'd50, 8'd65, 6'd63, 1'b1);

    // Reset mid-road discards the partial road.
    push(32'h3, 8'd1, 1'b0);
    push(32'h2, 8'd2, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_nfits", 64'(bus.nfits), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_no_valid", 64'(bus.out_valid), 64'd0);
    bus.chisq_cut = 32'h5;
    push(32'h5, 8'd3, 1'b1);
    get_record("post_rst", 32'h5, 8'd3, 6'd1, 1'b1);

    // Random roads against the reference model.
    for (int r = 0; r < 40; r++) begin
      len = $urandom_range(1, 8);
      cut = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFF : 32'($urandom_range(0, 16));
      bus.chisq_cut = cut;
      m_c.delete(); m_id.delete();
      for (int f = 0; f < len; f++) begin
        v = ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFF : 32'($urandom_range(0, 15));
        m_c.push_back(v);
        m_id.push_back(8'($urandom));
        push(m_c[f], m_id[f], f == len - 1);
      end
      mb = m_c[0]; mi = m_id[0];
      foreach (m_c[i]) if (m_c[i] < mb) begin mb = m_c[i]; mi = m_id[i]; end
      get_record($sformatf("rnd%0d", r), mb, mi, 6'((len > 63) ? 63 : len),
                 (mb <= cut) && (mb != 32'hFFFFFFFF));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
